// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter
//   Round-robin arbiter in front of one shared enabled register. Requesters
//   offer data over valid/ready. The winner's data is loaded into the
//   register, and then grants are blocked for hold_cycles_p cycles so the
//   register stays stable.
//
// Ports
//   clk_i       : clock, all state updates on posedge
//   reset_i     : asynchronous, active-low reset
//   valid_i     : per-requester request
//   data_i      : requester k data in [k*width_p +: width_p]
//   ready_o     : one-hot-or-zero grant (combinational)
//   q_o         : shared register contents
//   grant_id_o  : index of the requester that last wrote q_o
//   update_o    : one-cycle pulse, q_o changed this cycle
//   busy_o      : high while holding after a write
module rr_reg_arbiter #(
    parameter int unsigned num_req_p     = 4,
    parameter int unsigned width_p       = 8,
    parameter int unsigned hold_cycles_p = 2,
    localparam int unsigned id_w_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_req_p-1:0]           valid_i,
    input  logic [num_req_p*width_p-1:0]   data_i,
    output logic [num_req_p-1:0]           ready_o,
    output logic [width_p-1:0]             q_o,
    output logic [id_w_lp-1:0]             grant_id_o,
    output logic                           update_o,
    output logic                           busy_o
);

    localparam int unsigned cnt_w_lp =
        (hold_cycles_p > 0) ? $clog2(hold_cycles_p + 1) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
    logic [id_w_lp-1:0]    ptr_q, ptr_d;
    logic [width_p-1:0]    q_q, q_d;
    logic [id_w_lp-1:0]    grant_id_q, grant_id_d;
    logic                  update_q, update_d;

    logic                  any_valid;
    logic [id_w_lp-1:0]    winner_id;
    logic [num_req_p-1:0]  winner_oh;
    logic [width_p-1:0]    winner_data;
    logic                  handshake;

    // Scan ptr, ptr+1, ... (mod num_req_p); the first valid found wins.
    always_comb begin
        int unsigned        idx;
        logic [id_w_lp-1:0] idx_w;
        any_valid = 1'b0;
        winner_id = '0;
        winner_oh = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= num_req_p) begin
                idx = idx - num_req_p;
            end
            idx_w = id_w_lp'(idx);
            if (!any_valid && valid_i[idx_w]) begin
                any_valid        = 1'b1;
                winner_id        = idx_w;
                winner_oh[idx_w] = 1'b1;
            end
        end
    end

    // One-hot AND-OR mux of the winner's data.
    always_comb begin
        winner_data = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            winner_data = winner_data |
                          (data_i[k*width_p +: width_p] & {width_p{winner_oh[k]}});
        end
    end

    // Grants are suppressed in HOLD and, combinationally, while reset is held.
    always_comb begin
        handshake = any_valid && (state_q == ST_IDLE) && reset_i;
        ready_o   = handshake ? winner_oh : '0;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        q_d        = q_q;
        grant_id_d = grant_id_q;
        update_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    q_d        = winner_data;
                    grant_id_d = winner_id;
                    update_d   = 1'b1;
                    if (winner_id == id_w_lp'(num_req_p - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = winner_id + 1'b1;
                    end
                    if (hold_cycles_p > 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = cnt_w_lp'(hold_cycles_p);
                    end
                end
            end
            ST_HOLD: begin
                // Last hold cycle when the counter reaches 1.
                if (cnt_q <= cnt_w_lp'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            q_q        <= '0;
            grant_id_q <= '0;
            update_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            q_q        <= q_d;
            grant_id_q <= grant_id_d;
            update_q   <= update_d;
        end
    end

    assign q_o        = q_q;
    assign grant_id_o = grant_id_q;
    assign update_o   = update_q;
    assign busy_o     = (state_q == ST_HOLD);

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter with three configurations sharing one
// clock and reset: A (4 req, hold 2), B (4 req, hold 0), C (3 req, hold 1).
// Expected writes are queued when stimulus is driven and popped when the
// corresponding DUT pulses update_o.
module tb_rr_reg_arbiter;

    logic        clk;
    logic        reset_i;

    logic [3:0]  va, ra;
    logic [31:0] da;
    logic [7:0]  qa;
    logic [1:0]  ga;
    logic        ua, ba;

    logic [3:0]  vb, rb;
    logic [31:0] db;
    logic [7:0]  qb;
    logic [1:0]  gb;
    logic        ub, bb;

    logic [2:0]  vc, rc;
    logic [23:0] dc;
    logic [7:0]  qc;
    logic [1:0]  gc;
    logic        uc, bc;

    int vectors = 0;
    int fails   = 0;

    logic [15:0] sb_a[$];
    logic [15:0] sb_b[$];
    logic [15:0] sb_c[$];

    rr_reg_arbiter #(.num_req_p(4), .width_p(8), .hold_cycles_p(2)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .valid_i(va), .data_i(da),
        .ready_o(ra), .q_o(qa), .grant_id_o(ga), .update_o(ua), .busy_o(ba));

    rr_reg_arbiter #(.num_req_p(4), .width_p(8), .hold_cycles_p(0)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .valid_i(vb), .data_i(db),
        .ready_o(rb), .q_o(qb), .grant_id_o(gb), .update_o(ub), .busy_o(bb));

    rr_reg_arbiter #(.num_req_p(3), .width_p(8), .hold_cycles_p(1)) dut_c (
        .clk_i(clk), .reset_i(reset_i), .valid_i(vc), .data_i(dc),
        .ready_o(rc), .q_o(qc), .grant_id_o(gc), .update_o(uc), .busy_o(bc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_empty_fail(input string tag);
        fails++;
        $error("FAIL %s: observed empty scoreboard expected pending write", tag);
    endtask

    task automatic pop_a();
        logic [15:0] e;
        chk("a_update", 32'(ua), 32'd1);
        vectors++;
        assert (sb_a.size() != 0) else sb_empty_fail("a_sb");
        if (sb_a.size() != 0) begin
            e = sb_a.pop_front();
            chk("a_q", 32'(qa), 32'(e[7:0]));
            chk("a_id", 32'(ga), 32'(e[15:8]));
        end
    endtask

    task automatic pop_b();
        logic [15:0] e;
        chk("b_update", 32'(ub), 32'd1);
        vectors++;
        assert (sb_b.size() != 0) else sb_empty_fail("b_sb");
        if (sb_b.size() != 0) begin
            e = sb_b.pop_front();
            chk("b_q", 32'(qb), 32'(e[7:0]));
            chk("b_id", 32'(gb), 32'(e[15:8]));
        end
    endtask

    task automatic pop_c();
        logic [15:0] e;
        chk("c_update", 32'(uc), 32'd1);
        vectors++;
        assert (sb_c.size() != 0) else sb_empty_fail("c_sb");
        if (sb_c.size() != 0) begin
            e = sb_c.pop_front();
            chk("c_q", 32'(qc), 32'(e[7:0]));
            chk("c_id", 32'(gc), 32'(e[15:8]));
        end
    endtask

    initial begin
        // Reset held with every request asserted.
        reset_i = 1'b0;
        va = 4'hF; vb = 4'hF; vc = 3'h7;
        da = 32'h13121110; db = 32'h13121110; dc = 24'h222120;
        step();
        step();
        chk("rst_a_ready", 32'(ra), 32'd0);
        chk("rst_a_q", 32'(qa), 32'd0);
        chk("rst_a_id", 32'(ga), 32'd0);
        chk("rst_a_update", 32'(ua), 32'd0);
        chk("rst_a_busy", 32'(ba), 32'd0);
        chk("rst_b_ready", 32'(rb), 32'd0);
        chk("rst_c_ready", 32'(rc), 32'd0);
        chk("rst_c_busy", 32'(bc), 32'd0);
        va = '0; vb = '0; vc = '0;
        reset_i = 1'b1;
        step();
        chk("idle_a_update", 32'(ua), 32'd0);
        chk("idle_b_busy", 32'(bb), 32'd0);

        // Single write on A: requester 2 with A5, hold of 2 cycles.
        da[2*8 +: 8] = 8'hA5;
        va = 4'b0100;
        #1;
        chk("single_ready", 32'(ra), 32'b0100);
        sb_a.push_back({8'd2, 8'hA5});
        step();
        pop_a();
        chk("single_busy1", 32'(ba), 32'd1);
        chk("single_ready_h1", 32'(ra), 32'd0);
        step();
        chk("single_update_off", 32'(ua), 32'd0);
        chk("single_busy2", 32'(ba), 32'd1);
        chk("single_ready_h2", 32'(ra), 32'd0);
        step();
        chk("single_busy_end", 32'(ba), 32'd0);
        chk("single_ready_again", 32'(ra), 32'b0100);
        va = 4'b0000;
        step();
        chk("drop_no_update", 32'(ua), 32'd0);
        chk("drop_q_kept", 32'(qa), 32'hA5);

        // Pointer skip and wrap on A (ptr is 3 after the grant to 2).
        da[0 +: 8] = 8'h30;
        va = 4'b0001;
        #1;
        chk("wrap_ready0", 32'(ra), 32'b0001);
        sb_a.push_back({8'd0, 8'h30});
        step();
        pop_a();
        da[0 +: 8] = 8'h31;
        da[3*8 +: 8] = 8'h33;
        va = 4'b1001;
        step();
        chk("wrap_hold", 32'(ra), 32'd0);
        step();
        chk("skip_ready3", 32'(ra), 32'b1000);
        sb_a.push_back({8'd3, 8'h33});
        step();
        pop_a();
        step();
        step();
        chk("wrap_ready_back0", 32'(ra), 32'b0001);
        sb_a.push_back({8'd0, 8'h31});
        step();
        pop_a();
        chk("hold_before_rst", 32'(ba), 32'd1);

        // Asynchronous reset in the middle of the first HOLD cycle.
        #3;
        reset_i = 1'b0;
        #1;
        chk("midrst_busy", 32'(ba), 32'd0);
        chk("midrst_q", 32'(qa), 32'd0);
        chk("midrst_id", 32'(ga), 32'd0);
        chk("midrst_update", 32'(ua), 32'd0);
        chk("midrst_ready", 32'(ra), 32'd0);
        da = 32'h43424140;
        va = 4'hF;
        #1;
        chk("midrst_ready_valid", 32'(ra), 32'd0);
        #1;
        reset_i = 1'b1;
        #1;
        chk("postrst_ready", 32'(ra), 32'b0001);
        sb_a.push_back({8'd0, 8'h40});
        step();
        pop_a();
        va = 4'b0000;

        // Fairness on B, hold 0: back-to-back writes every cycle.
        db = 32'h13121110;
        vb = 4'hF;
        for (int i = 0; i < 6; i++) begin
            sb_b.push_back({8'(i % 4), 8'(8'h10 + i % 4)});
            step();
            pop_b();
            chk("fair_busy", 32'(bb), 32'd0);
        end
        vb = 4'b0000;
        step();
        chk("fair_update_off", 32'(ub), 32'd0);
        chk("fair_q_kept", 32'(qb), 32'h11);

        // Three requesters on C, hold 1: grants 0,1,2,0 every 2 cycles.
        dc = 24'h222120;
        vc = 3'b111;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("np2_ready", 32'(rc), 32'd1 << (i % 3));
            sb_c.push_back({8'(i % 3), 8'(8'h20 + i % 3)});
            step();
            pop_c();
            chk("np2_busy", 32'(bc), 32'd1);
            chk("np2_ready_hold", 32'(rc), 32'd0);
            step();
            chk("np2_update_off", 32'(uc), 32'd0);
            chk("np2_busy_off", 32'(bc), 32'd0);
        end
        vc = 3'b000;
        step();
        chk("np2_sb_drained", 32'(sb_c.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
